// File: rtl/mem_access_sequencer.sv
// Sequences CPU loads/stores onto a single-port, byte-masked, word-wide data memory.
// Boundary-crossing accesses are split into two aligned word accesses; loads are extended.
module mem_access_sequencer #(
   parameter int unsigned ADDR_W           = 30,
   parameter bit          ALLOW_MISALIGNED = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W+1:0] req_addr,
   input  logic [2:0]        req_func3,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_wmask,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [2:0] {StIdle, StAcc0, StAcc1, StCapt, StResp} state_t;

   state_t      state;
   logic        we_q;
   logic [1:0]  off_q;
   logic [2:0]  func3_q;
   logic        split_q;
   logic [3:0]  mask_hi_q;
   logic [31:0] data_hi_q;
   logic [31:0] r0_q;

   logic [1:0]  in_off;
   logic [7:0]  in_base;
   logic [7:0]  in_mask;
   logic [63:0] in_data;
   logic        in_split;
   logic        in_err;

   always_comb begin
      in_off = req_addr[1:0];
      case (req_func3[1:0])
         2'b00:   in_base = 8'h01;
         2'b01:   in_base = 8'h03;
         default: in_base = 8'h0F;
      endcase
      in_mask  = in_base << in_off;
      in_data  = {32'b0, req_wdata} << {in_off, 3'b000};
      in_split = |in_mask[7:4];
      in_err   = (req_func3[1:0] == 2'b11) ||
                 (!ALLOW_MISALIGNED && (((req_func3[1:0] == 2'b01) && in_off[0]) ||
                                        ((req_func3[1:0] == 2'b10) && (in_off != 2'b00))));
   end

   // In CAPT, mem_rdata is the only word (non-split) or the high word (split).
   logic [31:0] lo_word;
   logic [31:0] hi_word;
   logic [63:0] shifted;
   logic [31:0] ld_data;
   logic        sgn;

   always_comb begin
      lo_word = split_q ? r0_q : mem_rdata;
      hi_word = split_q ? mem_rdata : 32'b0;
      shifted = {hi_word, lo_word} >> {off_q, 3'b000};
      ld_data = 32'b0;
      sgn     = 1'b0;
      case (func3_q[1:0])
         2'b00: begin
            sgn     = shifted[7] & ~func3_q[2];
            ld_data = {{24{sgn}}, shifted[7:0]};
         end
         2'b01: begin
            sgn     = shifted[15] & ~func3_q[2];
            ld_data = {{16{sgn}}, shifted[15:0]};
         end
         default: ld_data = shifted[31:0];
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= StIdle;
         req_ready <= 1'b0;
         we_q      <= 1'b0;
         off_q     <= 2'b0;
         func3_q   <= 3'b0;
         split_q   <= 1'b0;
         mask_hi_q <= 4'b0;
         data_hi_q <= 32'b0;
         r0_q      <= 32'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'b0;
         rsp_err   <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wmask <= 4'b0;
         mem_wdata <= 32'b0;
      end else begin
         unique case (state)
            StIdle: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  we_q      <= req_we;
                  off_q     <= in_off;
                  func3_q   <= req_func3;
                  split_q   <= in_split;
                  mask_hi_q <= req_we ? in_mask[7:4] : 4'b0;
                  data_hi_q <= in_data[63:32];
                  if (in_err) begin
                     state     <= StResp;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                  end else begin
                     state     <= StAcc0;
                     mem_en    <= 1'b1;
                     mem_we    <= req_we;
                     mem_addr  <= req_addr[ADDR_W+1:2];
                     mem_wmask <= req_we ? in_mask[3:0] : 4'b0;
                     mem_wdata <= in_data[31:0];
                  end
               end
            end
            StAcc0: begin
               if (split_q) begin
                  state     <= StAcc1;
                  mem_addr  <= mem_addr + ADDR_W'(1);
                  mem_wmask <= mask_hi_q;
                  mem_wdata <= data_hi_q;
               end else begin
                  state     <= StCapt;
                  mem_en    <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_wmask <= 4'b0;
                  mem_wdata <= 32'b0;
               end
            end
            StAcc1: begin
               state     <= StCapt;
               r0_q      <= mem_rdata;
               mem_en    <= 1'b0;
               mem_we    <= 1'b0;
               mem_wmask <= 4'b0;
               mem_wdata <= 32'b0;
            end
            StCapt: begin
               state     <= StResp;
               rsp_valid <= 1'b1;
               rsp_rdata <= we_q ? 32'b0 : ld_data;
            end
            StResp: begin
               state     <= StIdle;
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               rsp_rdata <= 32'b0;
               req_ready <= 1'b1;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer with a behavioural byte-masked memory.
// A second instance with misalignment rejection covers the strict configuration.
module tb_mem_access_sequencer;

   localparam int unsigned AW = 30;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_valid_s = 1'b0;
   logic          req_we = 1'b0;
   logic [AW+1:0] req_addr = '0;
   logic [2:0]    req_func3 = 3'b0;
   logic [31:0]   req_wdata = 32'b0;
   logic          req_ready, rsp_valid, rsp_err, mem_en, mem_we;
   logic [31:0]   rsp_rdata, mem_wdata;
   logic [AW-1:0] mem_addr;
   logic [3:0]    mem_wmask;
   logic [31:0]   mem_rdata = 32'b0;
   logic          req_ready_s, rsp_valid_s, rsp_err_s, mem_en_s, mem_we_s;
   logic [31:0]   rsp_rdata_s, mem_wdata_s;
   logic [AW-1:0] mem_addr_s;
   logic [3:0]    mem_wmask_s;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0]   mem [0:255];

   logic          o_en   [1:6];
   logic          o_we   [1:6];
   logic [AW-1:0] o_addr [1:6];
   logic [3:0]    o_mask [1:6];
   logic [31:0]   o_wd   [1:6];
   logic          o_rv   [1:6];
   logic          o_err  [1:6];
   logic [31:0]   o_rd   [1:6];

   always #5 clk = ~clk;

   mem_access_sequencer #(.ADDR_W(AW), .ALLOW_MISALIGNED(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_func3(req_func3), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wmask(mem_wmask),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   mem_access_sequencer #(.ADDR_W(AW), .ALLOW_MISALIGNED(1'b0)) u_dut_strict (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid_s), .req_ready(req_ready_s),
      .req_we(req_we), .req_addr(req_addr), .req_func3(req_func3), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid_s), .rsp_rdata(rsp_rdata_s), .rsp_err(rsp_err_s),
      .mem_en(mem_en_s), .mem_we(mem_we_s), .mem_addr(mem_addr_s), .mem_wmask(mem_wmask_s),
      .mem_wdata(mem_wdata_s), .mem_rdata(mem_rdata)
   );

   always @(posedge clk) begin
      if (mem_en && mem_we)
         for (int b = 0; b < 4; b++)
            if (mem_wmask[b]) mem[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      if (mem_en && !mem_we) mem_rdata <= mem[mem_addr[7:0]];
   end

   // Issue one request and record six cycles of outputs; index k = cycles after accept.
   task automatic issue(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] wd);
      int w;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_func3 = f3; req_wdata = wd;
      w = 0;
      while (!req_ready && w < 10) begin
         @(negedge clk);
         w++;
      end
      n_cmp++;
      if (req_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL accept_timeout got req_ready=%b want 1", req_ready);
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         o_en[k] = mem_en; o_we[k] = mem_we; o_addr[k] = mem_addr; o_mask[k] = mem_wmask;
         o_wd[k] = mem_wdata; o_rv[k] = rsp_valid; o_err[k] = rsp_err; o_rd[k] = rsp_rdata;
      end
   endtask

   task automatic test_reset();
      #12;
      n_cmp++;
      if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got %b want 0", req_ready); end
      n_cmp++;
      if ({mem_en, mem_we, mem_wmask, mem_wdata, rsp_valid, rsp_err, rsp_rdata} !== '0) begin
         n_bad++;
         $display("FAIL rst_outputs got en=%b rv=%b rd=%h want all 0", mem_en, rsp_valid, rsp_rdata);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready got %b want 1", req_ready); end
   endtask

   task automatic test_word_store();
      issue(1'b1, 32'h10, 3'b010, 32'hA1B2C3D4);
      n_cmp++;
      if ({o_en[1], o_we[1], o_addr[1], o_mask[1], o_wd[1]} !== {1'b1, 1'b1, 30'd4, 4'b1111, 32'hA1B2C3D4}) begin
         n_bad++;
         $display("FAIL ws_acc0 got en=%b we=%b a=%h m=%b d=%h want 1 1 4 1111 a1b2c3d4",
                  o_en[1], o_we[1], o_addr[1], o_mask[1], o_wd[1]);
      end
      n_cmp++;
      if ({o_en[2], o_we[2], o_mask[2], o_wd[2]} !== '0) begin
         n_bad++;
         $display("FAIL ws_idle_outs got en=%b m=%b d=%h want 0", o_en[2], o_mask[2], o_wd[2]);
      end
      n_cmp++;
      if ({o_rv[2], o_rv[3], o_rv[4]} !== 3'b010 || o_rd[3] !== 32'h0) begin
         n_bad++;
         $display("FAIL ws_rsp got rv=%b%b%b rd=%h want 010 0", o_rv[2], o_rv[3], o_rv[4], o_rd[3]);
      end
      n_cmp++;
      if (mem[4] !== 32'hA1B2C3D4) begin n_bad++; $display("FAIL ws_mem got %h want a1b2c3d4", mem[4]); end
   endtask

   task automatic test_split_store();
      mem[4] = 32'h0; mem[5] = 32'h0;
      issue(1'b1, 32'h13, 3'b001, 32'h0000BEEF);
      n_cmp++;
      if ({o_en[1], o_addr[1], o_mask[1], o_wd[1]} !== {1'b1, 30'd4, 4'b1000, 32'hEF000000}) begin
         n_bad++;
         $display("FAIL ss_acc0 got a=%h m=%b d=%h want 4 1000 ef000000", o_addr[1], o_mask[1], o_wd[1]);
      end
      n_cmp++;
      if ({o_en[2], o_addr[2], o_mask[2], o_wd[2]} !== {1'b1, 30'd5, 4'b0001, 32'h000000BE}) begin
         n_bad++;
         $display("FAIL ss_acc1 got a=%h m=%b d=%h want 5 0001 000000be", o_addr[2], o_mask[2], o_wd[2]);
      end
      n_cmp++;
      if ({o_rv[3], o_rv[4], o_rv[5]} !== 3'b010) begin
         n_bad++;
         $display("FAIL ss_latency got rv=%b%b%b want 010", o_rv[3], o_rv[4], o_rv[5]);
      end
      n_cmp++;
      if (mem[4] !== 32'hEF000000 || mem[5] !== 32'h000000BE) begin
         n_bad++;
         $display("FAIL ss_mem got %h %h want ef000000 000000be", mem[4], mem[5]);
      end
   endtask

   task automatic test_byte_load();
      issue(1'b0, 32'h22, 3'b000, 32'h0);
      n_cmp++;
      if (o_rv[3] !== 1'b1 || o_rd[3] !== 32'hFFFFFFF0) begin
         n_bad++;
         $display("FAIL lb_sign got rv=%b rd=%h want 1 fffffff0", o_rv[3], o_rd[3]);
      end
      n_cmp++;
      if (o_addr[1] !== 30'd8 || o_mask[1] !== 4'b0 || o_we[1] !== 1'b0) begin
         n_bad++;
         $display("FAIL lb_acc got a=%h m=%b we=%b want 8 0000 0", o_addr[1], o_mask[1], o_we[1]);
      end
      issue(1'b0, 32'h22, 3'b100, 32'h0);
      n_cmp++;
      if (o_rd[3] !== 32'h000000F0) begin n_bad++; $display("FAIL lbu_zero got %h want 000000f0", o_rd[3]); end
   endtask

   task automatic test_split_load();
      issue(1'b0, 32'h07, 3'b010, 32'h0);
      n_cmp++;
      if (o_addr[1] !== 30'd1 || o_addr[2] !== 30'd2 || o_en[2] !== 1'b1) begin
         n_bad++;
         $display("FAIL sl_addr got %h %h want 1 2", o_addr[1], o_addr[2]);
      end
      n_cmp++;
      if (o_rv[4] !== 1'b1 || o_rd[4] !== 32'h77665544) begin
         n_bad++;
         $display("FAIL sl_data got rv=%b rd=%h want 1 77665544", o_rv[4], o_rd[4]);
      end
   endtask

   task automatic test_reserved();
      issue(1'b0, 32'h10, 3'b011, 32'h0);
      n_cmp++;
      if ({o_rv[1], o_err[1], o_rd[1]} !== {1'b1, 1'b1, 32'h0}) begin
         n_bad++;
         $display("FAIL rsv_rsp got rv=%b err=%b rd=%h want 1 1 0", o_rv[1], o_err[1], o_rd[1]);
      end
      n_cmp++;
      if ({o_en[1], o_en[2], o_en[3], o_rv[2], o_err[2]} !== 5'b0) begin
         n_bad++;
         $display("FAIL rsv_noacc got en=%b%b%b rv2=%b err2=%b want 0", o_en[1], o_en[2], o_en[3],
                  o_rv[2], o_err[2]);
      end
   endtask

   task automatic test_misaligned_reject();
      logic seen_en;
      @(negedge clk);
      req_valid_s = 1'b1; req_we = 1'b0; req_addr = 32'h01; req_func3 = 3'b001;
      n_cmp++;
      if (req_ready_s !== 1'b1) begin n_bad++; $display("FAIL mis_ready got %b want 1", req_ready_s); end
      @(posedge clk);
      #1 req_valid_s = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({rsp_valid_s, rsp_err_s, rsp_rdata_s} !== {1'b1, 1'b1, 32'h0}) begin
         n_bad++;
         $display("FAIL mis_rsp got rv=%b err=%b rd=%h want 1 1 0", rsp_valid_s, rsp_err_s, rsp_rdata_s);
      end
      seen_en = mem_en_s;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         seen_en = seen_en | mem_en_s;
      end
      n_cmp++;
      if (seen_en !== 1'b0) begin n_bad++; $display("FAIL mis_noacc got mem_en=%b want 0", seen_en); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] rdy;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h07; req_func3 = 3'b010;
      @(posedge clk);
      #1 req_addr = 32'h22; req_func3 = 3'b100;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         rdy[k-1] = req_ready;
         if (k == 4) begin
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h77665544) begin
               n_bad++;
               $display("FAIL b2b_first got rv=%b rd=%h want 1 77665544", rsp_valid, rsp_rdata);
            end
         end
      end
      @(negedge clk);
      n_cmp++;
      if (rdy !== 4'b0000 || req_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL b2b_ready got %b then %b want 0000 then 1", rdy, req_ready);
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int k = 1; k <= 3; k++) @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h000000F0) begin
         n_bad++;
         $display("FAIL b2b_second got rv=%b rd=%h want 1 000000f0", rsp_valid, rsp_rdata);
      end
   endtask

   task automatic test_reset_mid();
      mem[6] = 32'h0; mem[7] = 32'h0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h1B; req_func3 = 3'b001;
      req_wdata = 32'h0000BEEF;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if (mem_en !== 1'b1 || mem_addr !== 30'd7) begin
         n_bad++;
         $display("FAIL rm_acc1 got en=%b a=%h want 1 7", mem_en, mem_addr);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({mem_en, mem_we, mem_wmask, mem_wdata, rsp_valid, req_ready} !== '0) begin
         n_bad++;
         $display("FAIL rm_abort got en=%b we=%b m=%b d=%h rdy=%b want 0", mem_en, mem_we, mem_wmask,
                  mem_wdata, req_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rm_ready got %b want 1", req_ready); end
      n_cmp++;
      if (mem[6] !== 32'hEF000000 || mem[7] !== 32'h0) begin
         n_bad++;
         $display("FAIL rm_mem got %h %h want ef000000 00000000", mem[6], mem[7]);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[1] = 32'h44332211;
      mem[2] = 32'h88776655;
      mem[8] = 32'h00F00000;
      test_reset();
      test_word_store();
      test_split_store();
      test_byte_load();
      test_split_load();
      test_reserved();
      test_misaligned_reject();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
